// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter.
//  master_e    : which core port owns an access (fetch or load/store)
//  arb_state_e : access-stage FSM state
//  access_t    : contents of the registered access stage
//  addr_oob()  : window range check on a byte address
package sram_arb_pkg;

    // Word-address width of a 32-bit byte address (bits [31:2]).
    localparam int unsigned SRAM_WORD_AW = 30;

    typedef enum logic {
        M_FETCH = 1'b0,
        M_DATA  = 1'b1
    } master_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                    valid;
        master_e                 who;
        logic                    write;
        logic                    oob;
        logic [SRAM_WORD_AW-1:0] addr;
        logic [31:0]             wdata;
    } access_t;

    // Out of window when below the base or at/after base + words*4.
    function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] base,
                                      input int unsigned words);
        logic [31:0] off;
        off = addr - base;
        return (addr < base) || ((off >> 2) >= words);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of core-side handshakes and SRAM-side bus for sram_port_arbiter.
//  slave  : arbiter view (takes requests and HRDATA, drives ready/response/SRAM controls)
//  master : system view (core ports plus the SRAM model)
interface sram_port_arbiter_if;
    // Fetch port (read-only)
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_ready;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;
    // Load/store port
    logic        m1_req;
    logic        m1_write;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ready;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;
    // SRAM bus
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    modport slave (
        input  m0_req, m0_addr,
        output m0_ready, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_write, m1_addr, m1_wdata,
        output m1_ready, m1_rvalid, m1_rdata, m1_err,
        output HSEL, HADDR, HWRITE, HWDATA,
        input  HRDATA
    );

    modport master (
        output m0_req, m0_addr,
        input  m0_ready, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_write, m1_addr, m1_wdata,
        input  m1_ready, m1_rvalid, m1_rdata, m1_err,
        input  HSEL, HADDR, HWRITE, HWDATA,
        output HRDATA
    );

endinterface

// File: rtl/sram_arb_grant.sv
// Grant logic for the two SRAM masters. Produces a one-hot (or empty) grant that is only
// ever given to a requesting master.
// Build option SRAM_ARB_RR_EN:
//  defined   : round-robin on contention via a last-grant flop (reset = M_DATA, so fetch
//              wins the first contention).
//  undefined : load/store has priority; a saturating counter of consecutive fetch denials
//              hands the contended cycle to fetch once it reaches MAX_WAIT.
// Ports:
//  clk_i, rst_i         clock, asynchronous active-high reset
//  m0_req_i, m1_req_i   requests from fetch and load/store
//  gnt_m0_o, gnt_m1_o   grant (combinational)
module sram_arb_grant #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic m0_req_i,
    input  logic m1_req_i,
    output logic gnt_m0_o,
    output logic gnt_m1_o
);
    import sram_arb_pkg::*;

`ifdef SRAM_ARB_RR_EN
    master_e last_q, last_d;

    always_comb begin
        gnt_m0_o = 1'b0;
        gnt_m1_o = 1'b0;
        if (m0_req_i && m1_req_i) begin
            if (last_q == M_DATA) gnt_m0_o = 1'b1;
            else                  gnt_m1_o = 1'b1;
        end else begin
            gnt_m0_o = m0_req_i;
            gnt_m1_o = m1_req_i;
        end
        last_d = last_q;
        if (gnt_m0_o)      last_d = M_FETCH;
        else if (gnt_m1_o) last_d = M_DATA;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= M_DATA;
        else       last_q <= last_d;
    end
`else
    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0] wait_q, wait_d;
    logic          starved;

    assign starved = (wait_q == WAIT_MAX);

    always_comb begin
        gnt_m0_o = 1'b0;
        gnt_m1_o = 1'b0;
        if (m0_req_i && m1_req_i) begin
            if (starved) gnt_m0_o = 1'b1;
            else         gnt_m1_o = 1'b1;
        end else begin
            gnt_m0_o = m0_req_i;
            gnt_m1_o = m1_req_i;
        end
        // Count only consecutive denials; any fetch accept or idle fetch clears it.
        wait_d = '0;
        if (m0_req_i && !gnt_m0_o) begin
            wait_d = starved ? wait_q : wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port word SRAM between instruction fetch (M0, read-only) and
// load/store (M1). One access per cycle: accept in cycle N, SRAM bus driven in N+1 (stores
// commit at the end of N+1, read data captured at the same edge), response in N+2.
// Out-of-window accesses never select the SRAM and return err with zero data.
// Build option SRAM_ARB_RR_EN selects round-robin arbitration (see sram_arb_grant).
// Ports:
//  HCLK, HRESET  clock, asynchronous active-high reset
//  bus (slave)   fetch/load-store handshakes and responses, SRAM HSEL/HADDR/HWRITE/HWDATA
//                (all registered) and HRDATA
module sram_port_arbiter #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned SRAM_WORDS = 8192,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    sram_port_arbiter_if.slave   bus
);
    import sram_arb_pkg::*;

    logic       gnt_m0, gnt_m1;
    arb_state_e state_q, state_d;
    access_t    acc_q, acc_d;
    logic       hsel_q, hsel_d;
    logic       hwrite_q, hwrite_d;
    logic       m0_rvalid_q, m0_rvalid_d, m0_err_q, m0_err_d;
    logic       m1_rvalid_q, m1_rvalid_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [31:0] resp_data;

    sram_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk_i    (HCLK),
        .rst_i    (HRESET),
        .m0_req_i (bus.m0_req),
        .m1_req_i (bus.m1_req),
        .gnt_m0_o (gnt_m0),
        .gnt_m1_o (gnt_m1)
    );

    assign bus.m0_ready = gnt_m0;
    assign bus.m1_ready = gnt_m1;

    // Access stage: capture the granted request.
    always_comb begin
        acc_d = '0;
        if (gnt_m1) begin
            acc_d.valid = 1'b1;
            acc_d.who   = M_DATA;
            acc_d.write = bus.m1_write;
            acc_d.oob   = addr_oob(bus.m1_addr, ADDR_BASE, SRAM_WORDS);
            acc_d.addr  = bus.m1_addr[31:2];
            acc_d.wdata = bus.m1_wdata;
        end else if (gnt_m0) begin
            acc_d.valid = 1'b1;
            acc_d.who   = M_FETCH;
            acc_d.oob   = addr_oob(bus.m0_addr, ADDR_BASE, SRAM_WORDS);
            acc_d.addr  = bus.m0_addr[31:2];
        end
        state_d  = acc_d.valid ? ACCESS : IDLE;
        hsel_d   = acc_d.valid & ~acc_d.oob;
        hwrite_d = hsel_d & acc_d.write;
    end

    // Response stage: rdata holds between responses; valid/err are single-cycle pulses.
    always_comb begin
        m0_rvalid_d = 1'b0;
        m0_err_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rvalid_d = 1'b0;
        m1_err_d    = 1'b0;
        m1_rdata_d  = m1_rdata_q;
        resp_data   = acc_q.oob ? 32'h0 : bus.HRDATA;
        if (state_q == ACCESS && acc_q.valid) begin
            if (acc_q.who == M_FETCH) begin
                m0_rvalid_d = 1'b1;
                m0_rdata_d  = resp_data;
                m0_err_d    = acc_q.oob;
            end else if (!acc_q.write) begin
                m1_rvalid_d = 1'b1;
                m1_rdata_d  = resp_data;
                m1_err_d    = acc_q.oob;
            end else begin
                // Stores only report a range error, never data.
                m1_err_d = acc_q.oob;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            hsel_q      <= 1'b0;
            hwrite_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m0_err_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rvalid_q <= 1'b0;
            m1_err_q    <= 1'b0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hsel_q      <= hsel_d;
            hwrite_q    <= hwrite_d;
            m0_rvalid_q <= m0_rvalid_d;
            m0_err_q    <= m0_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rvalid_q <= m1_rvalid_d;
            m1_err_q    <= m1_err_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign bus.HSEL      = hsel_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HADDR     = {acc_q.addr, 2'b00};
    assign bus.HWDATA    = acc_q.wdata;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m0_err    = m0_err_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m1_err    = m1_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 8192-word SRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_sram_port_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sram_port_arbiter_if bus();

    sram_port_arbiter #(
        .ADDR_BASE  (32'h0000_0000),
        .SRAM_WORDS (8192),
        .MAX_WAIT   (4)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    // SRAM model: combinational read, write at the rising edge, plus a preload port.
    logic [31:0] mem [0:8191];
    logic        pre_we;
    logic [12:0] pre_idx;
    logic [31:0] pre_dat;

    assign bus.HRDATA = bus.HSEL ? mem[bus.HADDR[14:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we)                      mem[pre_idx]         <= pre_dat;
        else if (bus.HSEL && bus.HWRITE) mem[bus.HADDR[14:2]] <= bus.HWDATA;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req   = 1'b0;
        bus.m0_addr  = 32'h0;
        bus.m1_req   = 1'b0;
        bus.m1_write = 1'b0;
        bus.m1_addr  = 32'h0;
        bus.m1_wdata = 32'h0;
    endtask

    task automatic preload(input logic [12:0] idx, input logic [31:0] dat);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_dat = dat;
        tick();
        pre_we  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.HSEL, bus.HWRITE, bus.HADDR, bus.HWDATA} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_sram_bus: got %b/%b/%h/%h want 0/0/0/0",
                     bus.HSEL, bus.HWRITE, bus.HADDR, bus.HWDATA);
        end
        n_cmp++;
        if ({bus.m0_rvalid, bus.m0_err, bus.m0_rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_m0_resp: got %b/%b/%h want 0/0/0",
                     bus.m0_rvalid, bus.m0_err, bus.m0_rdata);
        end
        n_cmp++;
        if ({bus.m1_rvalid, bus.m1_err, bus.m1_rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_m1_resp: got %b/%b/%h want 0/0/0",
                     bus.m1_rvalid, bus.m1_err, bus.m1_rdata);
        end
        n_cmp++;
        if ({bus.m0_ready, bus.m1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: got %b%b want 00", bus.m0_ready, bus.m1_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_m0_read();
        preload(13'd4, 32'hDEAD_BEEF);
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h10;
        @(negedge clk);
        n_cmp++;
        if ({bus.m0_ready, bus.m1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL m0_read_ready: got %b%b want 10", bus.m0_ready, bus.m1_ready);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if ({bus.HSEL, bus.HWRITE, bus.HADDR} !== {2'b10, 32'h10}) begin
            n_err++;
            $display("FAIL m0_read_bus: got %b/%b/%h want 1/0/00000010",
                     bus.HSEL, bus.HWRITE, bus.HADDR);
        end
        n_cmp++;
        if (bus.m0_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL m0_read_early_rvalid: got %b want 0", bus.m0_rvalid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.m0_rvalid, bus.m0_err, bus.m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL m0_read_resp: got %b/%b/%h want 1/0/deadbeef",
                     bus.m0_rvalid, bus.m0_err, bus.m0_rdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.HSEL, bus.m0_rvalid, bus.m0_rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL m0_read_idle_hold: got %b/%b/%h want 0/0/deadbeef",
                     bus.HSEL, bus.m0_rvalid, bus.m0_rdata);
        end
        tick();
    endtask

    task automatic test_store_then_read();
        bus.m1_req   = 1'b1;
        bus.m1_write = 1'b1;
        bus.m1_addr  = 32'h20;
        bus.m1_wdata = 32'h1234;
        @(negedge clk);
        n_cmp++;
        if (bus.m1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL store_ready: got %b want 1", bus.m1_ready);
        end
        tick();
        idle_inputs();
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h20;
        @(negedge clk);
        n_cmp++;
        if ({bus.HSEL, bus.HWRITE, bus.HWDATA, bus.m0_ready} !== {2'b11, 32'h1234, 1'b1}) begin
            n_err++;
            $display("FAIL store_bus: got %b/%b/%h ready %b want 1/1/00001234 ready 1",
                     bus.HSEL, bus.HWRITE, bus.HWDATA, bus.m0_ready);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if ({bus.m1_rvalid, bus.m1_err, bus.HWRITE} !== 3'b000) begin
            n_err++;
            $display("FAIL store_no_resp: got %b/%b hwrite %b want 0/0 hwrite 0",
                     bus.m1_rvalid, bus.m1_err, bus.HWRITE);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'h1234}) begin
            n_err++;
            $display("FAIL store_then_read: got %b/%h want 1/00001234",
                     bus.m0_rvalid, bus.m0_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        do_reset();
        bus.m0_req   = 1'b1;
        bus.m0_addr  = 32'h10;
        bus.m1_req   = 1'b1;
        bus.m1_write = 1'b0;
        bus.m1_addr  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef SRAM_ARB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_gnt = (i % 5 == 4) ? 2'b10 : 2'b01;
`endif
            n_cmp++;
            if ({bus.m0_ready, bus.m1_ready} !== exp_gnt) begin
                n_err++;
                $display("FAIL contention_grant[%0d]: got %b%b want %b",
                         i, bus.m0_ready, bus.m1_ready, exp_gnt);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_oob();
        logic seen_hsel;
        preload(13'd8191, 32'hCAFE_F00D);
        seen_hsel    = 1'b0;
        bus.m1_req   = 1'b1;
        bus.m1_write = 1'b0;
        bus.m1_addr  = 32'h8000;
        @(negedge clk);
        n_cmp++;
        if (bus.m1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL oob_ready: got %b want 1", bus.m1_ready);
        end
        tick();
        // Store just past the window, right behind the load.
        bus.m1_write = 1'b1;
        bus.m1_addr  = 32'h8004;
        bus.m1_wdata = 32'h77;
        @(negedge clk);
        seen_hsel = seen_hsel | bus.HSEL;
        tick();
        // Last in-window word.
        bus.m1_write = 1'b0;
        bus.m1_addr  = 32'h7FFC;
        @(negedge clk);
        seen_hsel = seen_hsel | bus.HSEL;
        n_cmp++;
        if ({bus.m1_rvalid, bus.m1_err, bus.m1_rdata} !== {2'b11, 32'h0}) begin
            n_err++;
            $display("FAIL oob_load_resp: got %b/%b/%h want 1/1/00000000",
                     bus.m1_rvalid, bus.m1_err, bus.m1_rdata);
        end
        n_cmp++;
        if (seen_hsel !== 1'b0) begin
            n_err++;
            $display("FAIL oob_hsel: got %b want 0", seen_hsel);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if ({bus.m1_rvalid, bus.m1_err} !== 2'b01) begin
            n_err++;
            $display("FAIL oob_store_err: got rvalid %b err %b want 0/1",
                     bus.m1_rvalid, bus.m1_err);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.m1_rvalid, bus.m1_err, bus.m1_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            n_err++;
            $display("FAIL oob_last_word: got %b/%b/%h want 1/0/cafef00d",
                     bus.m1_rvalid, bus.m1_err, bus.m1_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic hsel_before;
        preload(13'd12, 32'hAAAA_0000);
        bus.m1_req   = 1'b1;
        bus.m1_write = 1'b1;
        bus.m1_addr  = 32'h30;
        bus.m1_wdata = 32'h55;
        @(negedge clk);
        n_cmp++;
        if (bus.m1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: got %b want 1", bus.m1_ready);
        end
        tick();
        idle_inputs();
        #1;
        hsel_before = bus.HSEL;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({hsel_before, bus.HSEL} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_mid_hsel: got before %b after %b want 1/0", hsel_before, bus.HSEL);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem[12] !== 32'hAAAA_0000) begin
            n_err++;
            $display("FAIL rst_mid_no_commit: got %h want aaaa0000", mem[12]);
        end
        n_cmp++;
        if ({bus.m1_rvalid, bus.m1_err, bus.HSEL} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_no_resp: got %b/%b/%b want 0/0/0",
                     bus.m1_rvalid, bus.m1_err, bus.HSEL);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h1111_1111;
        exp_data[1] = 32'h2222_2222;
        exp_data[2] = 32'h3333_3333;
        preload(13'd0, exp_data[0]);
        preload(13'd1, exp_data[1]);
        preload(13'd2, exp_data[2]);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                bus.m1_req   = 1'b1;
                bus.m1_write = 1'b0;
                bus.m1_addr  = 32'(i * 4);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            n_cmp++;
            if (bus.m1_ready !== (i < 3)) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.m1_ready, (i < 3));
            end
            if (i >= 2) begin
                n_cmp++;
                if ({bus.m1_rvalid, bus.m1_rdata} !== {1'b1, exp_data[i-2]}) begin
                    n_err++;
                    $display("FAIL b2b_resp[%0d]: got %b/%h want 1/%h",
                             i, bus.m1_rvalid, bus.m1_rdata, exp_data[i-2]);
                end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (bus.m1_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_tail_rvalid: got %b want 0", bus.m1_rvalid);
        end
        tick();
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        pre_we  = 1'b0;
        pre_idx = '0;
        pre_dat = '0;
        idle_inputs();
        test_reset();
        test_m0_read();
        test_store_then_read();
        test_contention();
        test_oob();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
